// File: rtl/eq_frame_checker_if.sv
// Bit-pair stream and frame-result bundle for eq_frame_checker.
// The master side drives the pair stream and control; the slave side is the checker.
interface eq_frame_checker_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic             bit_valid;
  logic             i0;
  logic             i1;
  logic             busy;
  logic             done;
  logic             match;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] first_err_idx;

  modport master (
    output start, abort, bit_valid, i0, i1,
    input  busy, done, match, mismatch_cnt, first_err_idx
  );

  modport slave (
    input  start, abort, bit_valid, i0, i1,
    output busy, done, match, mismatch_cnt, first_err_idx
  );
endinterface

// File: rtl/eq_frame_checker.sv
// Serial frame comparator: checks N bit pairs for equality and reports the
// mismatch count, the first mismatching index and an all-equal flag once the
// frame completes. Every output comes straight from a flop.
module eq_frame_checker #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  eq_frame_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] N_VAL    = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] err_acc;
  logic [CNT_W-1:0] first_err;
  logic [CNT_W-1:0] err_acc_nxt;
  logic [CNT_W-1:0] first_err_nxt;

  logic             busy_q;
  logic             done_q;
  logic             match_q;
  logic [CNT_W-1:0] mismatch_cnt_q;
  logic [CNT_W-1:0] first_err_idx_q;

  logic             eq_bit;
  logic             take_bit;
  logic             final_bit;

  assign eq_bit = (~bus.i0 & ~bus.i1) | (bus.i0 & bus.i1);

  // abort outranks a simultaneous valid pair, so a discarded frame never
  // touches the accumulators or the result registers.
  assign take_bit  = (state == RUN) && bus.bit_valid && !bus.abort;
  assign final_bit = take_bit && (idx == LAST_IDX);

  // Accumulator values including the pair being sampled this cycle; the
  // result registers load these so the final pair is counted.
  assign err_acc_nxt   = eq_bit ? err_acc : err_acc + CNT_W'(1);
  assign first_err_nxt = (!eq_bit && (first_err == N_VAL)) ? idx : first_err;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (bus.abort)                                  state_nxt = IDLE;
        else if (bus.bit_valid && (idx == LAST_IDX))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered status flags, derived from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  // Frame accumulators: cleared on start, advanced on each accepted pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      err_acc   <= '0;
      first_err <= '0;
    end else if ((state == IDLE) && bus.start) begin
      idx       <= '0;
      err_acc   <= '0;
      first_err <= N_VAL;
    end else if (take_bit) begin
      idx       <= idx + CNT_W'(1);
      err_acc   <= err_acc_nxt;
      first_err <= first_err_nxt;
    end
  end

  // Result registers: loaded only when a frame completes, held otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q         <= 1'b0;
      mismatch_cnt_q  <= '0;
      first_err_idx_q <= '0;
    end else if (final_bit) begin
      match_q         <= (err_acc_nxt == '0);
      mismatch_cnt_q  <= err_acc_nxt;
      first_err_idx_q <= first_err_nxt;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.match         = match_q;
  assign bus.mismatch_cnt  = mismatch_cnt_q;
  assign bus.first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_eq_frame_checker.sv
// Self-checking bench for eq_frame_checker. Expected frame results are
// computed from the driven pairs, queued when the final pair is driven and
// compared when done pulses.
module tb_eq_frame_checker;

  localparam int N     = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             match;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] first;
  } exp_t;

  logic clk;
  logic reset_n;

  eq_frame_checker_if #(.CNT_W(CNT_W)) bus ();

  eq_frame_checker #(.N(N), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t last_exp;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result: pair i differs when a[i] != b[i].
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.cnt   = '0;
    e.first = CNT_W'(N);
    for (int i = 0; i < N; i++) begin
      if (a[i] != b[i]) begin
        if (e.first == CNT_W'(N)) e.first = CNT_W'(i);
        e.cnt = e.cnt + CNT_W'(1);
      end
    end
    e.match = (e.cnt == '0);
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match a queued frame.
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("match",         bus.match,         e.match);
        check("mismatch_cnt",  bus.mismatch_cnt,  e.cnt);
        check("first_err_idx", bus.first_err_idx, e.first);
      end
    end
  end

  // Feeds N pairs to a checker already in RUN, with `gap` idle cycles
  // between pairs, optionally asserting abort alongside the final pair.
  task automatic drive_pairs(input logic [N-1:0] a, input logic [N-1:0] b,
                             input int gap, input bit abort_last);
    for (int i = 0; i < N; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          bus.bit_valid = 1'b0;
          @(negedge clk);
          check("busy_gap", bus.busy, 1);
          @(posedge clk); #1;
        end
      end
      bus.bit_valid = 1'b1;
      bus.i0        = a[i];
      bus.i1        = b[i];
      if (i == N - 1) begin
        if (abort_last) begin
          bus.abort = 1'b1;
        end else begin
          last_exp = model(a, b);
          sb.push_back(last_exp);
        end
      end
      @(posedge clk); #1;
    end
    bus.bit_valid = 1'b0;
    bus.abort     = 1'b0;
    @(negedge clk);
    if (abort_last) begin
      check("abort_no_done",    bus.done,          0);
      check("abort_idle",       bus.busy,          0);
      check("abort_hold_match", bus.match,         last_exp.match);
      check("abort_hold_cnt",   bus.mismatch_cnt,  last_exp.cnt);
      check("abort_hold_first", bus.first_err_idx, last_exp.first);
    end else begin
      check("done_latency", bus.done, 1);
      check("busy_in_done", bus.busy, 0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
  endtask

  task automatic run_frame(input logic [N-1:0] a, input logic [N-1:0] b,
                           input int gap, input bit abort_last);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("busy_rise", bus.busy, 1);
    drive_pairs(a, b, gap, abort_last);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.bit_valid = 1'b0;
    bus.i0        = 1'b0;
    bus.i1        = 1'b0;
    last_exp      = '0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  bus.busy,          0);
    check("rst_done",  bus.done,          0);
    check("rst_match", bus.match,         0);
    check("rst_cnt",   bus.mismatch_cnt,  0);
    check("rst_first", bus.first_err_idx, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // All pairs equal, alternating 00/11.
    run_frame(8'hAA, 8'hAA, 0, 1'b0);
    // Mismatches at 2 (01), 5 (10) and 7 (01), including the final pair.
    run_frame(8'h20, 8'h84, 0, 1'b0);
    // Same frame with three idle cycles between pairs.
    run_frame(8'h20, 8'h84, 3, 1'b0);
    // Abort together with a mismatching final pair, then a clean frame.
    run_frame(8'h00, 8'h80, 0, 1'b1);
    run_frame(8'h55, 8'h55, 1, 1'b0);

    // Reset mid-frame after four pairs with one mismatch.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bit_valid = 1'b1;
      bus.i0        = 1'b1;
      bus.i1        = (i != 1);
      @(posedge clk); #1;
    end
    bus.bit_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy",  bus.busy,          0);
    check("arst_done",  bus.done,          0);
    check("arst_match", bus.match,         0);
    check("arst_cnt",   bus.mismatch_cnt,  0);
    check("arst_first", bus.first_err_idx, 0);
    last_exp = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(8'h3C, 8'h3C, 0, 1'b0);

    // start held high across two frames.
    bus.start = 1'b1;
    @(posedge clk); #1;
    drive_pairs(8'hF0, 8'hF1, 0, 1'b0);
    check("held_start_idle", bus.busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("held_start_run", bus.busy, 1);
    drive_pairs(8'h0F, 8'h0F, 0, 1'b0);
    bus.start = 1'b0;
    @(negedge clk);
    check("held_start_end", bus.busy, 0);

    // A few random frames with random gaps.
    for (int k = 0; k < 4; k++) begin
      ra = N'($urandom);
      rb = ra ^ N'($urandom & $urandom);
      run_frame(ra, rb, int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
